// File: rtl/adc_spi_sampler_pkg.sv
// Shared types and timing helpers for the periodic SPI ADC sampler.
package adc_spi_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    CS_HOLD  = 3'd3,
    PUBLISH  = 3'd4
  } state_t;

  // Clock edges from the adc_cs_n falling edge to the data_refresh rising edge.
  function automatic int conv_cycles(input int data_w, input int clk_div);
    return clk_div * (2 * data_w + 2);
  endfunction

endpackage

// File: rtl/adc_spi_sampler_if.sv
// Mode-0 SPI link between the sampler (master) and the serial ADC (slave).
interface adc_spi_sampler_if;

  logic adc_cs_n;
  logic adc_sclk;
  logic adc_miso;

  modport master (
    output adc_cs_n,
    output adc_sclk,
    input  adc_miso
  );

  modport slave (
    input  adc_cs_n,
    input  adc_sclk,
    output adc_miso
  );

endinterface

// File: rtl/adc_spi_sampler_tick.sv
// Free-running period counter; tick marks the start of each sample period.
module sample_tick_gen #(
  parameter int SAMPLE_PERIOD = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  logic [CW-1:0] cnt_q;

  // Held at zero while disabled so the first enabled edge always ticks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!enable) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(SAMPLE_PERIOD - 1)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick = enable && (cnt_q == '0);

endmodule

// File: rtl/adc_spi_sampler.sv
// Periodically reads a serial ADC over mode-0 SPI and publishes each word
// on sample with a one-cycle data_refresh strobe for the downstream filter.
module adc_spi_sampler
  import adc_spi_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int CLK_DIV       = 2,
  parameter int SAMPLE_PERIOD = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  adc_spi_sampler_if.master  spi,
  output logic [DATA_W-1:0]  sample,
  output logic               data_refresh,
  output logic               busy,
  output state_t             state
);

  localparam int HW = $clog2(CLK_DIV + 1);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  generate
    if (CLK_DIV < 1) begin : g_bad_div
      $error("adc_spi_sampler: CLK_DIV must be at least 1");
    end
    if (SAMPLE_PERIOD < conv_cycles(DATA_W, CLK_DIV) + CLK_DIV + 1) begin : g_bad_period
      $error("adc_spi_sampler: SAMPLE_PERIOD too short for one conversion");
    end
  endgenerate

  logic tick;

  sample_tick_gen #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(enable),
    .tick  (tick)
  );

  state_t            state_q, state_d;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic              phase_q, phase_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              refresh_q, refresh_d;
  logic              half_done;

  assign half_done = (hcnt_q == HW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hcnt_q    <= '0;
      phase_q   <= 1'b0;
      bit_q     <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      shreg_q   <= '0;
      sample_q  <= '0;
      refresh_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      shreg_q   <= shreg_d;
      sample_q  <= sample_d;
      refresh_q <= refresh_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    shreg_d   = shreg_q;
    sample_d  = sample_q;
    refresh_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = CS_SETUP;
          cs_n_d  = 1'b0;
          hcnt_d  = '0;
        end
      end

      CS_SETUP: begin
        if (half_done) begin
          state_d = SHIFT;
          hcnt_d  = '0;
          phase_d = 1'b0;
          bit_d   = '0;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end

      // phase 0 = low half of a bit, phase 1 = high half; MISO is captured
      // on the edge that raises sclk, after a full low half of settling.
      SHIFT: begin
        if (half_done) begin
          hcnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            sclk_d  = 1'b1;
            shreg_d = {shreg_q[DATA_W-2:0], spi.adc_miso};
          end else begin
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            if (bit_q == BW'(DATA_W - 1)) begin
              state_d = CS_HOLD;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end

      CS_HOLD: begin
        if (half_done) begin
          state_d   = PUBLISH;
          hcnt_d    = '0;
          cs_n_d    = 1'b1;
          sample_d  = shreg_q;
          refresh_d = 1'b1;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end

      PUBLISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // data_refresh is a strobe, not a handshake: it is high for exactly the one
  // cycle in which sample first carries a new word, and the consumer must take
  // it then; there is no ready/back-pressure path.
  assign spi.adc_cs_n = cs_n_q;
  assign spi.adc_sclk = sclk_q;
  assign sample       = sample_q;
  assign data_refresh = refresh_q;
  assign busy         = (state_q != IDLE);
  assign state        = state_q;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Directed bench for adc_spi_sampler: table-driven single conversions plus
// hand-written periodic, enable-drop and mid-conversion reset sequences.
module tb_adc_spi_sampler;
  import adc_spi_pkg::*;

  localparam int DATA_W        = 16;
  localparam int CLK_DIV       = 2;
  localparam int SAMPLE_PERIOD = 100;
  localparam int EXP_LAT       = 68;
  localparam int BUDGET        = conv_cycles(DATA_W, CLK_DIV) + 2 * SAMPLE_PERIOD;

  typedef struct {
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] exp_sample;
    int                exp_edges;
    int                exp_latency;
  } vec_t;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] sample;
  logic              data_refresh;
  logic              busy;
  state_t            state;

  adc_spi_sampler_if spi ();

  adc_spi_sampler #(
    .DATA_W       (DATA_W),
    .CLK_DIV      (CLK_DIV),
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .spi         (spi),
    .sample      (sample),
    .data_refresh(data_refresh),
    .busy        (busy),
    .state       (state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int cmp_cnt = 0;
  int fail_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ADC model: MSB appears when cs_n falls, next bit after each sclk fall.
  logic [DATA_W-1:0] adc_q[$];
  logic [DATA_W-1:0] adc_word = '0;
  int                bit_idx = 0;
  logic              miso_v = 1'b0;
  logic              m_prev_cs = 1'b1;
  logic              m_prev_sclk = 1'b0;
  assign spi.adc_miso = miso_v;

  always @(negedge clk) begin
    if (m_prev_cs && spi.adc_cs_n === 1'b0) begin
      automatic logic [DATA_W-1:0] w = (adc_q.size() > 0) ? adc_q.pop_front() : adc_word;
      adc_word <= w;
      bit_idx  <= DATA_W - 1;
      miso_v   <= w[DATA_W-1];
    end else if (spi.adc_cs_n === 1'b0 && m_prev_sclk && spi.adc_sclk === 1'b0 && bit_idx > 0) begin
      bit_idx <= bit_idx - 1;
      miso_v  <= adc_word[bit_idx-1];
    end
    m_prev_cs   <= (spi.adc_cs_n !== 1'b0);
    m_prev_sclk <= (spi.adc_sclk === 1'b1);
  end

  // Monitor and scoreboard
  logic [DATA_W-1:0] exp_q[$];
  int                cs_fall_hist[$];
  int                cs_fall_cnt = 0;
  int                cs_fall_cyc = 0;
  int                refresh_cnt = 0;
  int                edges = 0;
  int                last_edges = 0;
  int                last_latency = 0;
  logic [DATA_W-1:0] last_sample = '0;
  int                viol_cnt = 0;
  logic              prev_cs = 1'b1;
  logic              prev_sclk = 1'b0;
  logic              prev_ref = 1'b0;

  always @(negedge clk) begin
    if (prev_cs && spi.adc_cs_n === 1'b0) begin
      cs_fall_cnt <= cs_fall_cnt + 1;
      cs_fall_cyc <= cyc;
      cs_fall_hist.push_back(cyc);
      edges       <= 0;
    end else if (!prev_sclk && spi.adc_sclk === 1'b1) begin
      edges <= edges + 1;
    end
    if (spi.adc_sclk === 1'b1 && spi.adc_cs_n !== 1'b0) viol_cnt <= viol_cnt + 1;
    if (data_refresh === 1'b1) begin
      refresh_cnt  <= refresh_cnt + 1;
      last_sample  <= sample;
      last_edges   <= edges;
      last_latency <= cyc - cs_fall_cyc;
      check("strobe_single_cycle", {31'd0, prev_ref}, 32'd0);
      check("strobe_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) check("sb_sample", {16'd0, sample}, {16'd0, exp_q.pop_front()});
    end
    prev_cs   <= (spi.adc_cs_n !== 1'b0);
    prev_sclk <= (spi.adc_sclk === 1'b1);
    prev_ref  <= (data_refresh === 1'b1);
  end

  // Driver tasks
  task automatic wait_cs_fall(input int target, input string name);
    int n = 0;
    while (cs_fall_cnt < target && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, cs_fall_cnt >= target}, 32'd1);
  endtask

  task automatic wait_refresh(input int target, input string name);
    int n = 0;
    while (refresh_cnt < target && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, refresh_cnt >= target}, 32'd1);
  endtask

  vec_t tbl[5];

  initial begin
    int base_c;
    int base_r;
    int exp_fall;

    tbl[0] = '{16'hA5C3, 16'hA5C3, 16, 68};
    tbl[1] = '{16'h0000, 16'h0000, 16, 68};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 16, 68};
    tbl[3] = '{16'h8001, 16'h8001, 16, 68};
    tbl[4] = '{16'h0001, 16'h0001, 16, 68};

    // Reset held for 5 cycles with enable high
    rst_n  = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_ctrl", {28'd0, spi.adc_cs_n, spi.adc_sclk, data_refresh, busy}, 32'h8);
      check("rst_sample", {16'd0, sample}, 32'd0);
    end
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_rst", {29'd0, spi.adc_cs_n, busy, state == IDLE}, 32'h5);

    // Table-driven single conversions
    for (int i = 0; i < 5; i++) begin
      adc_q.push_back(tbl[i].word);
      exp_q.push_back(tbl[i].exp_sample);
      base_c = cs_fall_cnt;
      base_r = refresh_cnt;
      enable = 1'b1;
      wait_cs_fall(base_c + 1, "tbl_cs_fall_timeout");
      enable = 1'b0;
      wait_refresh(base_r + 1, "tbl_refresh_timeout");
      check("tbl_sample", {16'd0, last_sample}, {16'd0, tbl[i].exp_sample});
      check("tbl_sclk_edges", last_edges, tbl[i].exp_edges);
      check("tbl_latency", last_latency, tbl[i].exp_latency);
      repeat (20) @(negedge clk);
      check("tbl_one_conv", cs_fall_cnt - base_c, 32'd1);
      check("tbl_one_strobe", refresh_cnt - base_r, 32'd1);
      check("tbl_held", {16'd0, sample}, {16'd0, tbl[i].exp_sample});
    end

    // Periodic: three conversions 100 cycles apart
    base_c = cs_fall_cnt;
    base_r = refresh_cnt;
    for (int v = 1; v <= 3; v++) begin
      adc_q.push_back(DATA_W'(v));
      exp_q.push_back(DATA_W'(v));
    end
    enable = 1'b1;
    wait_cs_fall(base_c + 3, "per_cs_fall_timeout");
    enable = 1'b0;
    wait_refresh(base_r + 3, "per_refresh_timeout");
    check("per_gap_1", cs_fall_hist[base_c+1] - cs_fall_hist[base_c], SAMPLE_PERIOD);
    check("per_gap_2", cs_fall_hist[base_c+2] - cs_fall_hist[base_c+1], SAMPLE_PERIOD);
    check("per_last_sample", {16'd0, last_sample}, 32'd3);
    check("per_latency", last_latency, EXP_LAT);
    repeat (120) @(negedge clk);
    check("per_three_conv", cs_fall_cnt - base_c, 32'd3);
    check("per_three_strobes", refresh_cnt - base_r, 32'd3);

    // Enable dropped 20 cycles into a conversion
    base_c = cs_fall_cnt;
    base_r = refresh_cnt;
    adc_q.push_back(16'h1234);
    exp_q.push_back(16'h1234);
    enable = 1'b1;
    wait_cs_fall(base_c + 1, "drop_cs_fall_timeout");
    while (cyc < cs_fall_cyc + 20) @(negedge clk);
    enable = 1'b0;
    check("drop_busy", {31'd0, busy}, 32'd1);
    wait_refresh(base_r + 1, "drop_refresh_timeout");
    check("drop_sample", {16'd0, last_sample}, 32'h1234);
    check("drop_latency", last_latency, EXP_LAT);
    repeat (150) @(negedge clk);
    check("drop_no_new_conv", cs_fall_cnt - base_c, 32'd1);

    // Re-enable: cs_n falls at the first edge that samples enable=1
    adc_q.push_back(16'h5A5A);
    exp_q.push_back(16'h5A5A);
    base_r = refresh_cnt;
    exp_fall = cyc + 1;
    enable = 1'b1;
    wait_cs_fall(base_c + 2, "reen_cs_fall_timeout");
    check("reen_fall_cycle", cs_fall_cyc, exp_fall);
    enable = 1'b0;
    wait_refresh(base_r + 1, "reen_refresh_timeout");
    check("reen_sample", {16'd0, last_sample}, 32'h5A5A);
    repeat (10) @(negedge clk);

    // Reset 30 cycles into a conversion
    base_c = cs_fall_cnt;
    base_r = refresh_cnt;
    adc_q.push_back(16'hBEEF);
    enable = 1'b1;
    wait_cs_fall(base_c + 1, "rstmid_cs_fall_timeout");
    while (cyc < cs_fall_cyc + 29) @(negedge clk);
    check("rstmid_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_ctrl", {28'd0, spi.adc_cs_n, spi.adc_sclk, data_refresh, busy}, 32'h8);
    check("rstmid_sample", {16'd0, sample}, 32'd0);
    check("rstmid_state", {29'd0, state}, {29'd0, IDLE});
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    check("rstmid_no_strobe", refresh_cnt - base_r, 32'd0);
    check("rstmid_sample_held", {16'd0, sample}, 32'd0);

    // Final report
    check("sclk_only_under_cs", viol_cnt, 32'd0);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
